// File: rtl/onion_pwm_capture_pkg.sv
// -----------------------------------------------------------------------------
// onion_pwm_capture_pkg
// Shared definitions for the ONION PWM capture path: default resolution and
// counter width, glitch-filter default length, FSM state encoding and the
// nominal-period helper (2^resolution) also used by the generator side.
// Optional feature macro: ONION_PWM_CAPTURE_GLITCH_FILTER_EN (see onion_sync_edge).
// -----------------------------------------------------------------------------
package onion_pwm_capture_pkg;

   localparam int unsigned PWM_RES_BITS_DEF = 32'd8;
   localparam int unsigned CNT_WIDTH_DEF    = 32'd16;
   localparam int unsigned FILTER_LEN_DEF   = 32'd4;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } state_t;

   // Nominal PWM period for a given duty-code resolution.
   function automatic int unsigned nominal_period(input int unsigned res_bits);
      return 32'd1 << res_bits;
   endfunction

endpackage

// File: rtl/onion_pwm_capture_if.sv
// -----------------------------------------------------------------------------
// onion_pwm_capture_if
// Measurement result bus of the PWM capture block.
//   period_o        last rise-to-rise period in clk cycles (0 after timeout)
//   high_o          high time inside that period (0 after timeout)
//   duty_o          recovered duty code, updated only when match_o
//   match_o         period equals the nominal 2^PWM_RESOLUTION_BITS
//   valid_o         one-cycle pulse, result fields just updated
//   static_o        no rising edge seen before the timeout
//   static_level_o  synchronised input level captured at the timeout
// Modports: master (capture block drives), slave (consumer reads).
// -----------------------------------------------------------------------------
interface onion_pwm_capture_if
   import onion_pwm_capture_pkg::*;
#(
   parameter int unsigned PWM_RESOLUTION_BITS = PWM_RES_BITS_DEF,
   parameter int unsigned CNT_WIDTH           = CNT_WIDTH_DEF
);

   logic [CNT_WIDTH-1:0]           period_o;
   logic [CNT_WIDTH-1:0]           high_o;
   logic [PWM_RESOLUTION_BITS-1:0] duty_o;
   logic                           match_o;
   logic                           valid_o;
   logic                           static_o;
   logic                           static_level_o;

   modport master (
      output period_o, high_o, duty_o, match_o, valid_o, static_o, static_level_o
   );

   modport slave (
      input  period_o, high_o, duty_o, match_o, valid_o, static_o, static_level_o
   );

endinterface

// File: rtl/onion_sync_edge.sv
// -----------------------------------------------------------------------------
// onion_sync_edge
// Brings an asynchronous input into the clk domain and flags its rising edges.
// Reusable for any slow asynchronous control input.
//   clk    in  clock
//   reset  in  asynchronous active-low reset
//   raw    in  asynchronous input
//   level  out synchronised (and, if enabled, filtered) level
//   rise   out one-cycle rising-edge flag, combinational from level
// With ONION_PWM_CAPTURE_GLITCH_FILTER_EN defined, a level change is accepted
// only after FILTER_LEN consecutive samples of the new level, so shorter pulses
// vanish; both edges get the same extra delay, keeping widths exact.
// -----------------------------------------------------------------------------
module onion_sync_edge
   import onion_pwm_capture_pkg::*;
#(
`ifdef ONION_PWM_CAPTURE_GLITCH_FILTER_EN
   parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   logic s1_r;
   logic s2_r;
   logic s3_r;
   logic lvl_s;

   // Two-flop synchroniser for the asynchronous input.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s1_r <= raw;
         s2_r <= s1_r;
      end
   end

`ifdef ONION_PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int unsigned RUN_W = $clog2(FILTER_LEN + 32'd1);

   logic [RUN_W-1:0] run_r;
   logic             filt_r;

   // Counts consecutive samples that disagree with the accepted level; any
   // agreeing sample restarts the count, so only a stable new level is taken.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_r  <= '0;
         filt_r <= 1'b0;
      end else if (s2_r == filt_r) begin
         run_r  <= '0;
      end else if (run_r == RUN_W'(FILTER_LEN - 32'd1)) begin
         run_r  <= '0;
         filt_r <= s2_r;
      end else begin
         run_r  <= run_r + RUN_W'(32'd1);
      end
   end

   assign lvl_s = filt_r;
`else
   assign lvl_s = s2_r;
`endif

   // Delay flop for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s3_r <= 1'b0;
      end else begin
         s3_r <= lvl_s;
      end
   end

   assign level = lvl_s;
   assign rise  = lvl_s & ~s3_r;

endmodule

// File: rtl/onion_pwm_capture.sv
// -----------------------------------------------------------------------------
// onion_pwm_capture
// Measures period (rise to rise) and high time of an external PWM waveform in
// clk cycles and recovers the duty code when the period is 2^PWM_RESOLUTION_BITS.
//   clk    in  clock
//   reset  in  asynchronous active-low reset
//   PWM_i  in  asynchronous PWM input
//   cap    out result bus (onion_pwm_capture_if.master)
// Optional macro ONION_PWM_CAPTURE_GLITCH_FILTER_EN enables the input glitch
// filter and the FILTER_LEN parameter.
// -----------------------------------------------------------------------------
module onion_pwm_capture
   import onion_pwm_capture_pkg::*;
#(
   parameter int unsigned PWM_RESOLUTION_BITS = PWM_RES_BITS_DEF,
   parameter int unsigned CNT_WIDTH           = CNT_WIDTH_DEF
`ifdef ONION_PWM_CAPTURE_GLITCH_FILTER_EN
   ,
   parameter int unsigned FILTER_LEN          = FILTER_LEN_DEF
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                PWM_i,
   onion_pwm_capture_if.master cap
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(32'd1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] NOMINAL = CNT_WIDTH'(nominal_period(PWM_RESOLUTION_BITS));

   logic level_s;
   logic rise_s;

   state_t                         state_r,  state_s;
   logic [CNT_WIDTH-1:0]           per_cnt_r, per_cnt_s;
   logic [CNT_WIDTH-1:0]           hi_cnt_r,  hi_cnt_s;
   logic [CNT_WIDTH-1:0]           period_r,  period_s;
   logic [CNT_WIDTH-1:0]           high_r,    high_s;
   logic [PWM_RESOLUTION_BITS-1:0] duty_r,    duty_s;
   logic                           match_r,   match_s;
   logic                           valid_r,   valid_s;
   logic                           static_r,  static_s;
   logic                           slevel_r,  slevel_s;
   logic [CNT_WIDTH-1:0]           hi_dec_s;

   onion_sync_edge
`ifdef ONION_PWM_CAPTURE_GLITCH_FILTER_EN
   #(.FILTER_LEN (FILTER_LEN))
`endif
   u_sync (
      .clk   (clk),
      .reset (reset),
      .raw   (PWM_i),
      .level (level_s),
      .rise  (rise_s)
   );

   // Next-state, counter and result computation.
   always_comb begin
      state_s   = state_r;
      per_cnt_s = per_cnt_r;
      hi_cnt_s  = hi_cnt_r;
      period_s  = period_r;
      high_s    = high_r;
      duty_s    = duty_r;
      match_s   = match_r;
      valid_s   = 1'b0;
      static_s  = static_r;
      slevel_s  = slevel_r;
      hi_dec_s  = hi_cnt_r - CNT_ONE;
      case (state_r)
         ST_IDLE: begin
            // First edge only opens a window; nothing to report yet.
            if (rise_s) begin
               state_s   = ST_MEASURE;
               per_cnt_s = CNT_ONE;
               hi_cnt_s  = CNT_ONE;
            end else begin
               state_s   = ST_IDLE;
            end
         end
         ST_MEASURE: begin
            // Rise is tested first so a rise on the timeout cycle still counts.
            if (rise_s) begin
               period_s  = per_cnt_r;
               high_s    = hi_cnt_r;
               valid_s   = 1'b1;
               static_s  = 1'b0;
               match_s   = (per_cnt_r == NOMINAL);
               if (per_cnt_r == NOMINAL) begin
                  duty_s = hi_dec_s[PWM_RESOLUTION_BITS-1:0];
               end else begin
                  duty_s = duty_r;
               end
               per_cnt_s = CNT_ONE;
               hi_cnt_s  = CNT_ONE;
            end else if (per_cnt_r == CNT_MAX) begin
               period_s  = '0;
               high_s    = '0;
               match_s   = 1'b0;
               valid_s   = 1'b1;
               static_s  = 1'b1;
               slevel_s  = level_s;
               state_s   = ST_IDLE;
            end else begin
               per_cnt_s = per_cnt_r + CNT_ONE;
               hi_cnt_s  = hi_cnt_r + {{(CNT_WIDTH-1){1'b0}}, level_s};
            end
         end
         default: begin
            state_s   = ST_IDLE;
            per_cnt_s = '0;
            hi_cnt_s  = '0;
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         per_cnt_r <= '0;
         hi_cnt_r  <= '0;
         period_r  <= '0;
         high_r    <= '0;
         duty_r    <= '0;
         match_r   <= 1'b0;
         valid_r   <= 1'b0;
         static_r  <= 1'b0;
         slevel_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         per_cnt_r <= per_cnt_s;
         hi_cnt_r  <= hi_cnt_s;
         period_r  <= period_s;
         high_r    <= high_s;
         duty_r    <= duty_s;
         match_r   <= match_s;
         valid_r   <= valid_s;
         static_r  <= static_s;
         slevel_r  <= slevel_s;
      end
   end

   assign cap.period_o       = period_r;
   assign cap.high_o         = high_r;
   assign cap.duty_o         = duty_r;
   assign cap.match_o        = match_r;
   assign cap.valid_o        = valid_r;
   assign cap.static_o       = static_r;
   assign cap.static_level_o = slevel_r;

endmodule

// File: tb/tb_onion_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_onion_pwm_capture
// Directed waveforms drive PWM_i; each expected measurement is pushed into a
// queue before the waveform that produces it, and a monitor pops one entry per
// valid_o pulse. A 12-bit counter width keeps the timeout at 4095 cycles.
// -----------------------------------------------------------------------------
module tb_onion_pwm_capture;

   localparam int unsigned RES = 8;
   localparam int unsigned CW  = 12;

   typedef struct packed {
      logic [CW-1:0]  period;
      logic [CW-1:0]  high;
      logic           match;
      logic [RES-1:0] duty;
      logic           stat;
      logic           lvl;
   } meas_t;

   logic  clk;
   logic  reset;
   logic  pwm;
   meas_t sb_q[$];
   int    n_chk;
   int    n_err;
   int    n_meas;
   logic  valid_prev;

   onion_pwm_capture_if #(.PWM_RESOLUTION_BITS(RES), .CNT_WIDTH(CW)) cap_if ();

   onion_pwm_capture #(.PWM_RESOLUTION_BITS(RES), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .PWM_i (pwm),
      .cap   (cap_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one scoreboard entry per valid_o pulse.
   always @(negedge clk) begin
      meas_t got;
      meas_t want;
      got = {cap_if.period_o, cap_if.high_o, cap_if.match_o, cap_if.duty_o,
             cap_if.static_o, cap_if.static_level_o};
      if (cap_if.valid_o) begin
         n_chk++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_valid: got period=%0d high=%0d, no result expected",
                     got.period, got.high);
         end else begin
            want = sb_q.pop_front();
            if (got !== want) begin
               n_err++;
               $display("FAIL meas%0d: got p=%0d h=%0d m=%0d d=%0d st=%0d lv=%0d, want p=%0d h=%0d m=%0d d=%0d st=%0d lv=%0d",
                        n_meas, got.period, got.high, got.match, got.duty, got.stat, got.lvl,
                        want.period, want.high, want.match, want.duty, want.stat, want.lvl);
            end
         end
         n_meas++;
         if (valid_prev) begin
            n_err++;
            $display("FAIL valid_back_to_back: got two consecutive valid cycles, want 1-cycle pulse");
         end
      end
      valid_prev <= cap_if.valid_o;
   end

   task automatic expect_m(input int p, input int h, input int m, input int d,
                           input int st, input int lv);
      meas_t e;
      e.period = CW'(p);
      e.high   = CW'(h);
      e.match  = 1'(m);
      e.duty   = RES'(d);
      e.stat   = 1'(st);
      e.lvl    = 1'(lv);
      sb_q.push_back(e);
   endtask

   task automatic hold(input logic lvl, input int n);
      pwm = lvl;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wave(input int h, input int p, input int n);
      repeat (n) begin
         hold(1'b1, h);
         hold(1'b0, p - h);
      end
   endtask

   task automatic check_zero(input string name);
      @(negedge clk);
      n_chk++;
      if ({cap_if.period_o, cap_if.high_o, cap_if.duty_o, cap_if.match_o, cap_if.valid_o,
           cap_if.static_o, cap_if.static_level_o} !== '0) begin
         n_err++;
         $display("FAIL %s: got p=%0d h=%0d d=%0d m=%0d v=%0d st=%0d lv=%0d, want all 0",
                  name, cap_if.period_o, cap_if.high_o, cap_if.duty_o, cap_if.match_o,
                  cap_if.valid_o, cap_if.static_o, cap_if.static_level_o);
      end
   endtask

   initial begin
      n_chk      = 0;
      n_err      = 0;
      n_meas     = 0;
      valid_prev = 1'b0;
      pwm        = 1'b0;
      reset      = 1'b0;

      // Reset held while the input toggles: nothing may come out.
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         pwm = ~pwm;
      end
      check_zero("reset_hold");
      pwm = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      hold(1'b0, 5);
      check_zero("after_reset");

      // Loopback, duty 63 at 256-cycle period.
      expect_m(256, 64, 1, 63, 0, 0);
      expect_m(256, 64, 1, 63, 0, 0);
      wave(64, 256, 3);

      // External 100-cycle period, 30 high: duty keeps 63.
      expect_m(256, 64, 1, 63, 0, 0);
      expect_m(100, 30, 0, 63, 0, 0);
      expect_m(100, 30, 0, 63, 0, 0);
      wave(30, 100, 3);

`ifndef ONION_PWM_CAPTURE_GLITCH_FILTER_EN
      // Minimum period of 2 cycles.
      expect_m(100, 30, 0, 63, 0, 0);
      expect_m(2, 1, 0, 63, 0, 0);
      expect_m(2, 1, 0, 63, 0, 0);
      wave(1, 2, 3);
      expect_m(2, 1, 0, 63, 0, 0);
`else
      expect_m(100, 30, 0, 63, 0, 0);
`endif
      // Duty 199 at nominal period.
      expect_m(256, 200, 1, 199, 0, 0);
      wave(200, 256, 2);

      // Stuck low, then stuck high: timeouts report the held level.
      expect_m(0, 0, 0, 199, 1, 0);
      hold(1'b0, 5000);
      expect_m(0, 0, 0, 199, 1, 1);
      hold(1'b1, 5000);

      // static_o clears only on the first measurement after two rises.
      hold(1'b0, 10);
      expect_m(100, 30, 0, 199, 0, 1);
      wave(30, 100, 2);

      // Rise on the timeout cycle wins (period 4095); period 4096 times out.
      expect_m(100, 30, 0, 199, 0, 1);
      wave(10, 4095, 1);
      expect_m(4095, 10, 0, 199, 0, 1);
      expect_m(0, 0, 0, 199, 1, 0);
      wave(10, 4096, 1);
      expect_m(100, 30, 0, 199, 0, 0);
      wave(30, 100, 2);

      // Reset in the middle of a period discards the partial counts.
      expect_m(100, 30, 0, 199, 0, 0);
      hold(1'b1, 30);
      hold(1'b0, 20);
      reset = 1'b0;
      hold(1'b0, 2);
      check_zero("reset_mid_period");
      reset = 1'b1;
      hold(1'b0, 5);
      expect_m(100, 30, 0, 0, 0, 0);
      expect_m(100, 30, 0, 0, 0, 0);
      wave(30, 100, 3);

      // 2-cycle glitch inside a 40-high / 100-period wave.
      expect_m(100, 30, 0, 0, 0, 0);
`ifdef ONION_PWM_CAPTURE_GLITCH_FILTER_EN
      expect_m(100, 40, 0, 0, 0, 0);
`else
      expect_m(60, 40, 0, 0, 0, 0);
      expect_m(40, 2, 0, 0, 0, 0);
      expect_m(60, 40, 0, 0, 0, 0);
`endif
      repeat (2) begin
         hold(1'b1, 40);
         hold(1'b0, 20);
         hold(1'b1, 2);
         hold(1'b0, 38);
      end
      hold(1'b0, 20);

      // Every pushed expectation must have been consumed.
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
         @(posedge clk);
      end
      n_chk++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL pending_results: got %0d results still outstanding, want 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
